sub_serial: RTL and testbench
=============================

SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin one subtraction A - B.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, sampled only when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse that marks the result as valid.
REQ-009 SHALL have port diff, output, WIDTH bits: the result A - B, modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1 bit: final borrow; 1 iff A < B as unsigned values.
REQ-011 SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-012 SHALL have port zero, output, 1 bit: 1 iff diff == 0.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only when busy=0 (IDLE or DONE); on acceptance: latch a and b into shift registers, clear internal borrow, clear bit counter, enter RUN.
REQ-015 SHALL ignore start while in RUN; latched operands unchanged.
REQ-016 SHALL process one bit per RUN cycle, LSB first, through one 1-bit full subtractor: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
REQ-017 SHALL shift each result bit into the MSB of the diff shift register and shift both operands right by one each RUN cycle.
REQ-018 SHALL leave RUN after exactly WIDTH bit cycles and enter DONE.
- Latency: start sampled at edge E0; done high in the cycle after edge E(WIDTH).
REQ-019 SHALL assert busy in RUN only, and done in DONE only, for exactly one cycle; DONE returns to IDLE unless start is accepted in DONE.
REQ-020 SHALL hold diff, borrow, ovf and zero stable from DONE until the next accepted start.
- Values during RUN are don't-care to the consumer but SHALL NOT be X.
REQ-021 SHALL compute ovf = (A[msb] != B[msb]) && (diff[msb] != A[msb]).
REQ-022 SHALL give diff = 0 and borrow = 0 for A == B; 0 - 1 SHALL give all-ones with borrow = 1.

Reset
REQ-023 SHALL on rst force state IDLE and busy, done, diff, borrow, ovf, zero, the counter and the internal borrow to 0, independent of clk.
REQ-024 SHALL, on rst asserted mid-RUN, abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 SHALL honour macro SUB_SERIAL_FLAGS_EN.
- Defined: ovf and zero computed per REQ-021/REQ-012.
- Undefined: ovf and zero ports still present, tied to 0, and no flag logic synthesized.
- borrow is always present and always computed.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant in shared package sub_serial_pkg.
REQ-027 SHALL instantiate exactly one sub-module, sub_1b: combinational 1-bit full subtractor with inputs x, y, bin and outputs d, bout.

Verification
REQ-028 SHALL cover: a=5, b=3, start 1 cycle -> busy for 32 cycles, done pulse at cycle 33; diff=2, borrow=0, ovf=0, zero=0.
REQ-029 SHALL cover: a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, ovf=0.
REQ-030 SHALL cover: a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1 (flags build), ovf=0 (no-flags build).
REQ-031 SHALL cover: a=b=0x1234ABCD -> diff=0, zero=1, borrow=0.
REQ-032 SHALL cover: start re-pulsed with new operands at cycle 10 of RUN -> ignored; result of the original operands with done at cycle 33.
REQ-033 SHALL cover: rst at cycle 15 of RUN -> all outputs 0 immediately, no done; next start with 9-4 -> diff=5.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_serial_pkg;

   localparam int unsigned SUB_SERIAL_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sub_1b.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module sub_1b (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial A - B, one bit per clock LSB first, result valid on a one-cycle done pulse.
// Macro SUB_SERIAL_FLAGS_EN enables the ovf/zero flags; otherwise both are tied to 0.
module sub_serial
   import sub_serial_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_SERIAL_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_d, bit_bout;
   logic             accept;
   logic             last;

   sub_1b u_sub_1b (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (borrow_q),
      .d    (bit_d),
      .bout (bit_bout)
   );

   assign accept = start && (state_q != RUN);
   assign last   = (cnt_q == CNT_W'(WIDTH - 1));

   // Next-state and datapath: shift one bit per RUN cycle, load on accepted start.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;

      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            a_d      = {1'b0, a_q[WIDTH-1:1]};
            b_d      = {1'b0, b_q[WIDTH-1:1]};
            diff_d   = {bit_d, diff_q[WIDTH-1:1]};
            borrow_d = bit_bout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) state_d = DONE;
         end
         DONE: begin
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         a_d      = a;
         b_d      = b;
         borrow_d = 1'b0;
         cnt_d    = '0;
      end

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

`ifdef SUB_SERIAL_FLAGS_EN
   logic ovf_q, ovf_d;
   logic zero_q, zero_d;

   // On the final bit, a_q[0]/b_q[0] hold the operand sign bits and bit_d is the result sign.
   always_comb begin
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (accept) begin
         ovf_d  = 1'b0;
         zero_d = 1'b0;
      end else if ((state_q == RUN) && last) begin
         ovf_d  = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
         zero_d = (diff_d == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign ovf  = ovf_q;
   assign zero = zero_q;
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial at the default 32-bit width.
module tb_sub_serial;

   localparam int unsigned W = 32;

`ifdef SUB_SERIAL_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;
   logic         zero;

   int n_cmp  = 0;
   int n_fail = 0;

   sub_serial dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one operation and wait (bounded) for done; cycle 1 is the first cycle after acceptance.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, diff, borrow, ovf, zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b ovf=%b zero=%b, want all 0",
                  busy, done, diff, borrow, ovf, zero);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bc;
      run_op(32'd5, 32'd3, lat, bc);
      n_cmp++;
      if (lat !== 33) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d, want 33", lat);
      end
      n_cmp++;
      if (bc !== 32) begin
         n_fail++;
         $display("FAIL basic_busy_cycles: got %0d, want 32", bc);
      end
      n_cmp++;
      if ({diff, borrow, ovf, zero} !== {32'd2, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_result: got diff=%h borrow=%b ovf=%b zero=%b, want 00000002 0 0 0",
                  diff, borrow, ovf, zero);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, busy, diff} !== {1'b0, 1'b0, 32'd2}) begin
         n_fail++;
         $display("FAIL basic_done_pulse_hold: got done=%b busy=%b diff=%h, want 0 0 00000002",
                  done, busy, diff);
      end
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [6];
      logic [W-1:0] vb [6];
      logic [W-1:0] vd [6];
      logic         vbo[6];
      logic         vov[6];
      logic         vz [6];
      int lat, bc;
      va[0] = 32'd3;          vb[0] = 32'd5;          vd[0] = 32'hFFFF_FFFE; vbo[0] = 1; vov[0] = 0;     vz[0] = 0;
      va[1] = 32'h8000_0000;  vb[1] = 32'd1;          vd[1] = 32'h7FFF_FFFF; vbo[1] = 0; vov[1] = FLAGS; vz[1] = 0;
      va[2] = 32'h1234_ABCD;  vb[2] = 32'h1234_ABCD;  vd[2] = 32'h0;         vbo[2] = 0; vov[2] = 0;     vz[2] = FLAGS;
      va[3] = 32'd0;          vb[3] = 32'd1;          vd[3] = 32'hFFFF_FFFF; vbo[3] = 1; vov[3] = 0;     vz[3] = 0;
      va[4] = 32'h7FFF_FFFF;  vb[4] = 32'hFFFF_FFFF;  vd[4] = 32'h8000_0000; vbo[4] = 1; vov[4] = FLAGS; vz[4] = 0;
      va[5] = 32'hA5A5_0F0F;  vb[5] = 32'h0101_0101;  vd[5] = 32'hA4A4_0E0E; vbo[5] = 0; vov[5] = 0;     vz[5] = 0;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], lat, bc);
         n_cmp++;
         if ({lat == 33, diff, borrow, ovf, zero} !== {1'b1, vd[i], vbo[i], vov[i], vz[i]}) begin
            n_fail++;
            $display("FAIL vector_%0d: got lat=%0d diff=%h borrow=%b ovf=%b zero=%b, want lat=33 diff=%h borrow=%b ovf=%b zero=%b",
                     i, lat, diff, borrow, ovf, zero, vd[i], vbo[i], vov[i], vz[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      @(negedge clk);
      a = 32'h0000_0010;
      b = 32'h0000_0001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      repeat (9) begin
         @(negedge clk);
         cyc++;
      end
      a = 32'd0;
      b = 32'd1;
      start = 1'b1;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if ({cyc == 33, diff, borrow} !== {1'b1, 32'h0000_000F, 1'b0}) begin
         n_fail++;
         $display("FAIL start_ignored: got cyc=%0d diff=%h borrow=%b, want cyc=33 diff=0000000f borrow=0",
                  cyc, diff, borrow);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      run_op(32'd100, 32'd1, lat, bc);
      a = 32'd20;
      b = 32'd30;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_accept_in_done: got busy=%b done=%b, want 1 0", busy, done);
      end
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if ({lat == 33, diff, borrow} !== {1'b1, 32'hFFFF_FFF6, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_result: got lat=%0d diff=%h borrow=%b, want lat=33 diff=fffffff6 borrow=1",
                  lat, diff, borrow);
      end
   endtask

   task automatic test_rst_mid_run();
      int lat, bc, done_seen;
      @(negedge clk);
      a = 32'hFFFF_0000;
      b = 32'h0000_1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_busy: got %b, want 1", busy);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, diff, borrow, ovf, zero} !== '0) begin
         n_fail++;
         $display("FAIL rst_async_clear: got busy=%b done=%b diff=%h borrow=%b ovf=%b zero=%b, want all 0",
                  busy, done, diff, borrow, ovf, zero);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      n_cmp++;
      if (done_seen !== 0) begin
         n_fail++;
         $display("FAIL rst_no_done: got %0d active cycles, want 0", done_seen);
      end
      run_op(32'd9, 32'd4, lat, bc);
      n_cmp++;
      if ({lat == 33, diff, borrow} !== {1'b1, 32'd5, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_restart: got lat=%0d diff=%h borrow=%b, want lat=33 diff=00000005 borrow=0",
                  lat, diff, borrow);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_start_ignored();
      test_back_to_back();
      test_rst_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
